axi_wr_responder: RTL and testbench
===================================

// Module: axi_wr_responder
// PURPOSE
// - AXI write-channel responder (slave end) for the speculative write path. Accepts one AW burst, collects its W beats into a flat burst buffer and issues the B response.
// - Hands each completed, non-blocked burst to the downstream slot logic as a one-cycle-valid bundle.
// - Single outstanding transaction. No interleaving, no AW/W reordering.
// PARAMETERS
// - PID_WIDTH      4   awid/bid width
// - PADDR_WIDTH    32  awaddr width
// - PLENGTH_WIDTH  3   awlen width; max burst = 2**PLENGTH_WIDTH beats (8)
// - PSIZE_WIDTH    2   awsize width (captured, not interpreted)
// - PAWUSER_WIDTH  2   awuser width; encodes REGULAR=00, BLOCK=01, DIVERT=10, UNLUCKY=11
// - BUS_BYTES      8   W data bus width in bytes; wstrb is BUS_BYTES bits
// PORTS
// - clk        in   1                       clock, all logic on rising edge
// - rst_n      in   1                       synchronous active-low reset
// - awvalid    in   1                       AW valid
// - awready    out  1                       AW ready
// - awid       in   PID_WIDTH               AW id
// - awaddr     in   PADDR_WIDTH             AW start address
// - awlen      in   PLENGTH_WIDTH           beats-1
// - awburst    in   2                       burst type; only INCR (01) is legal
// - awsize     in   PSIZE_WIDTH             beat size
// - awuser     in   PAWUSER_WIDTH           transaction type
// - wvalid     in   1                       W valid
// - wready     out  1                       W ready
// - wdata      in   8*BUS_BYTES             W data
// - wstrb      in   BUS_BYTES               W byte strobes
// - wlast      in   1                       last beat marker
// - bvalid     out  1                       B valid
// - bready     in   1                       B ready
// - bid        out  PID_WIDTH               B id (= captured awid)
// - bresp      out  2                       00 OKAY, 10 SLVERR
// - out_valid  out  1                       one-cycle pulse: burst bundle valid
// - out_id/out_addr/out_len/out_size/out_user  out  per AW field   captured AW fields
// - out_data   out  8*BUS_BYTES*2**PLENGTH_WIDTH   beat k at bits [k*8*BUS_BYTES +: 8*BUS_BYTES]
// - out_strb   out  BUS_BYTES*2**PLENGTH_WIDTH     beat k strobes; unwritten beats are 0
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE; awready=1, wready=0, bvalid=0, bresp=00, bid=0, out_valid=0.
//   - Buffer, strobes and captured fields are cleared to 0.
//   - Reset mid-burst abandons the burst: no B response, no out_valid.
// - FSM states: IDLE -> DATA -> RESP -> IDLE.
// - IDLE: awready=1, wready=0.
//   - On awvalid&awready, capture all AW fields, clear beat counter, err flag and buffer strobes, then go to DATA.
//   - W beats that arrive before the AW handshake are not accepted.
// - DATA: awready=0, wready=1. On each wvalid&wready:
//   - If beat<=awlen: write wdata/wstrb into slot beat, then beat++. The counter saturates at awlen+1 and excess beats are dropped.
//   - If wlast=1 and beat<awlen: set err, go to RESP (early last).
//   - If beat==awlen and wlast=0: set err, stay in DATA and drain beats until wlast=1.
//   - If wlast=1 and beat>=awlen: go to RESP.
// - Other error causes, latched at AW capture:
//   - awburst!=01 sets err; data is still collected.
//   - awuser==UNLUCKY sets err.
// - Entering RESP (the cycle after the last W handshake): bvalid=1, bid=captured awid, bresp = err ? 10 : 00.
//   - out_valid pulses for exactly that one cycle, unless err=1 or awuser==BLOCK.
//   - BLOCK bursts get bresp=OKAY but are never delivered.
// - RESP: bvalid, bid and bresp stay stable until bready. On bvalid&bready go to IDLE, with awready=1 on the next cycle.
// - out_* fields stay stable from the out_valid cycle until the next AW capture.
// - Latency:
//   - AW handshake at cycle N -> wready=1 at N+1.
//   - Last W handshake at M -> bvalid at M+1.
//   - B handshake at P -> awready at P+1.
//   - Minimum single-beat transaction is 3 cycles per burst.
// TESTING
// - INCR, awlen=3, awuser=REGULAR, id=5, 4 beats with wlast on beat 3 -> out_valid one cycle, out_strb beats 0-3 =FF and beats 4-7 =00, bid=5, bresp=00.
// - awuser=BLOCK, awlen=0 -> bresp=00, out_valid never asserts.
// - awlen=3, wlast on beat 1 -> RESP after beat 1, bresp=10, no out_valid, beats 2-3 strobes =0.
// - awlen=1 with wlast missing until beat 4 -> beats 2-4 dropped, bresp=10 after beat 4.
// - bready held low 5 cycles -> bvalid/bid/bresp stable, awready=0 throughout; awready=1 the cycle after bready.
// - rst_n=0 after beat 2 of awlen=7 -> next cycle awready=1, bvalid=0; a new AW is accepted cleanly.

Source files
------------

// File: rtl/axi_wr_responder.sv
// AXI write responder: takes one AW burst, gathers its W beats into a flat buffer,
// issues the B response and hands clean, non-blocked bursts downstream as a one-cycle bundle.
module axi_wr_responder #(
    parameter int unsigned PID_WIDTH     = 4,
    parameter int unsigned PADDR_WIDTH   = 32,
    parameter int unsigned PLENGTH_WIDTH = 3,
    parameter int unsigned PSIZE_WIDTH   = 2,
    parameter int unsigned PAWUSER_WIDTH = 2,
    parameter int unsigned BUS_BYTES     = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          awvalid,
    output logic                                          awready,
    input  logic [PID_WIDTH-1:0]                          awid,
    input  logic [PADDR_WIDTH-1:0]                        awaddr,
    input  logic [PLENGTH_WIDTH-1:0]                      awlen,
    input  logic [1:0]                                    awburst,
    input  logic [PSIZE_WIDTH-1:0]                        awsize,
    input  logic [PAWUSER_WIDTH-1:0]                      awuser,
    input  logic                                          wvalid,
    output logic                                          wready,
    input  logic [8*BUS_BYTES-1:0]                        wdata,
    input  logic [BUS_BYTES-1:0]                          wstrb,
    input  logic                                          wlast,
    output logic                                          bvalid,
    input  logic                                          bready,
    output logic [PID_WIDTH-1:0]                          bid,
    output logic [1:0]                                    bresp,
    output logic                                          out_valid,
    output logic [PID_WIDTH-1:0]                          out_id,
    output logic [PADDR_WIDTH-1:0]                        out_addr,
    output logic [PLENGTH_WIDTH-1:0]                      out_len,
    output logic [PSIZE_WIDTH-1:0]                        out_size,
    output logic [PAWUSER_WIDTH-1:0]                      out_user,
    output logic [8*BUS_BYTES*(2**PLENGTH_WIDTH)-1:0]     out_data,
    output logic [BUS_BYTES*(2**PLENGTH_WIDTH)-1:0]       out_strb
);

    localparam int unsigned DataW = 8 * BUS_BYTES;
    localparam int unsigned CntW  = PLENGTH_WIDTH + 1;

    localparam logic [1:0]               BurstIncr   = 2'b01;
    localparam logic [1:0]               RespOkay    = 2'b00;
    localparam logic [1:0]               RespSlverr  = 2'b10;
    localparam logic [PAWUSER_WIDTH-1:0] UserBlock   = PAWUSER_WIDTH'(1);
    localparam logic [PAWUSER_WIDTH-1:0] UserUnlucky = PAWUSER_WIDTH'(3);

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    state_e                   state_q;
    logic [CntW-1:0]          beat_q;
    logic                     err_q;

    logic                     w_hs;
    logic [CntW-1:0]          len_ext;
    logic                     beat_in_range;
    logic                     early_last;
    logic                     missing_last;
    logic                     err_now;
    logic [PLENGTH_WIDTH-1:0] slot;

    always_comb begin
        w_hs          = wvalid & wready;
        len_ext       = {1'b0, out_len};
        beat_in_range = (beat_q <= len_ext);
        early_last    = wlast && (beat_q < len_ext);
        missing_last  = !wlast && (beat_q == len_ext);
        err_now       = err_q | early_last | missing_last;
        slot          = beat_q[PLENGTH_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            err_q     <= 1'b0;
            awready   <= 1'b1;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= RespOkay;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_addr  <= '0;
            out_len   <= '0;
            out_size  <= '0;
            out_user  <= '0;
            out_data  <= '0;
            out_strb  <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (awvalid && awready) begin
                        out_id   <= awid;
                        out_addr <= awaddr;
                        out_len  <= awlen;
                        out_size <= awsize;
                        out_user <= awuser;
                        out_strb <= '0;
                        beat_q   <= '0;
                        err_q    <= (awburst != BurstIncr) || (awuser == UserUnlucky);
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        state_q  <= StData;
                    end
                end
                StData: begin
                    if (w_hs) begin
                        // Beats past awlen+1 are dropped; the counter stops there.
                        if (beat_in_range) begin
                            out_data[slot*DataW +: DataW]         <= wdata;
                            out_strb[slot*BUS_BYTES +: BUS_BYTES] <= wstrb;
                            beat_q                                <= beat_q + 1'b1;
                        end
                        err_q <= err_now;
                        if (wlast) begin
                            wready    <= 1'b0;
                            bvalid    <= 1'b1;
                            bid       <= out_id;
                            bresp     <= err_now ? RespSlverr : RespOkay;
                            out_valid <= !err_now && (out_user != UserBlock);
                            state_q   <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed bench for axi_wr_responder: one task per scenario, hand-computed expectations.
module tb_axi_wr_responder;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          awvalid, awready;
    logic [3:0]    awid;
    logic [31:0]   awaddr;
    logic [2:0]    awlen;
    logic [1:0]    awburst;
    logic [1:0]    awsize;
    logic [1:0]    awuser;
    logic          wvalid, wready;
    logic [63:0]   wdata;
    logic [7:0]    wstrb;
    logic          wlast;
    logic          bvalid, bready;
    logic [3:0]    bid;
    logic [1:0]    bresp;
    logic          out_valid;
    logic [3:0]    out_id;
    logic [31:0]   out_addr;
    logic [2:0]    out_len;
    logic [1:0]    out_size;
    logic [1:0]    out_user;
    logic [511:0]  out_data;
    logic [63:0]   out_strb;

    int checks = 0;
    int errors = 0;

    axi_wr_responder dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awburst(awburst), .awsize(awsize), .awuser(awuser),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .out_valid(out_valid), .out_id(out_id), .out_addr(out_addr), .out_len(out_len),
        .out_size(out_size), .out_user(out_user), .out_data(out_data), .out_strb(out_strb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] len,
                         input logic [1:0] burst, input logic [1:0] user);
        logic hs;
        hs      = 1'b0;
        awid    = id;
        awaddr  = addr;
        awlen   = len;
        awburst = burst;
        awsize  = 2'd3;
        awuser  = user;
        awvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = awready;
            step();
        end
        awvalid = 1'b0;
        checks++;
        if (!hs) begin errors++; $display("FAIL aw_timeout got no handshake exp handshake"); end
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL aw_to_wready got %b exp 1", wready); end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
        logic hs;
        hs     = 1'b0;
        wdata  = d;
        wstrb  = s;
        wlast  = last;
        wvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = wready;
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (!hs) begin
            checks++; errors++;
            $display("FAIL w_timeout got no handshake exp handshake");
        end
    endtask

    task automatic finish_b();
        logic hs;
        hs     = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = bvalid;
            step();
        end
        bready = 1'b0;
        checks++;
        if (!hs) begin errors++; $display("FAIL b_timeout got no handshake exp handshake"); end
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_to_awready got awready=%b bvalid=%b exp 1 0", awready, bvalid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got aw=%b w=%b b=%b exp 1 0 0", awready, wready, bvalid);
        end
        checks++;
        if (bresp !== 2'b00 || bid !== 4'h0 || out_valid !== 1'b0 || out_strb !== 64'h0) begin
            errors++;
            $display("FAIL reset_out got bresp=%b bid=%h ov=%b strb=%h exp 00 0 0 0",
                     bresp, bid, out_valid, out_strb);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_regular();
        do_aw(4'h5, 32'h0000_1000, 3'd3, 2'b01, 2'b00);
        send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
        send_beat(64'h3333_3333_3333_3333, 8'hFF, 1'b0);
        send_beat(64'h4444_4444_4444_4444, 8'hFF, 1'b1);
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'h5 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL reg_b got bvalid=%b bid=%h bresp=%b exp 1 5 00", bvalid, bid, bresp);
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL reg_out_valid got %b exp 1", out_valid); end
        checks++;
        if (out_strb !== 64'h0000_0000_FFFF_FFFF) begin
            errors++; $display("FAIL reg_strb got %h exp 00000000ffffffff", out_strb);
        end
        checks++;
        if (out_data[2*64 +: 64] !== 64'h3333_3333_3333_3333 ||
            out_data[3*64 +: 64] !== 64'h4444_4444_4444_4444) begin
            errors++;
            $display("FAIL reg_data got %h %h exp 3333.. 4444..", out_data[2*64 +: 64],
                     out_data[3*64 +: 64]);
        end
        checks++;
        if (out_addr !== 32'h0000_1000 || out_id !== 4'h5 || out_len !== 3'd3) begin
            errors++;
            $display("FAIL reg_fields got addr=%h id=%h len=%0d exp 1000 5 3", out_addr, out_id, out_len);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || bvalid !== 1'b1) begin
            errors++; $display("FAIL reg_pulse got ov=%b bvalid=%b exp 0 1", out_valid, bvalid);
        end
        finish_b();
    endtask

    task automatic test_w_before_aw();
        wdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        wstrb  = 8'hFF;
        wlast  = 1'b1;
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
                errors++;
                $display("FAIL early_w got wready=%b bvalid=%b awready=%b exp 0 0 1",
                         wready, bvalid, awready);
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic test_block();
        do_aw(4'h2, 32'h0000_2000, 3'd0, 2'b01, 2'b01);
        send_beat(64'h0A0A_0A0A_0A0A_0A0A, 8'hFF, 1'b1);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL block got bvalid=%b bresp=%b ov=%b exp 1 00 0", bvalid, bresp, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL block_late got ov=%b exp 0", out_valid); end
        finish_b();
    endtask

    task automatic test_early_last();
        do_aw(4'h6, 32'h0000_3000, 3'd3, 2'b01, 2'b00);
        send_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
        send_beat(64'h6666_6666_6666_6666, 8'hFF, 1'b1);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b10 || out_valid !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL early_last got bvalid=%b bresp=%b ov=%b wready=%b exp 1 10 0 0",
                     bvalid, bresp, out_valid, wready);
        end
        checks++;
        if (out_strb !== 64'h0000_0000_0000_FFFF) begin
            errors++; $display("FAIL early_last_strb got %h exp 000000000000ffff", out_strb);
        end
        finish_b();
    endtask

    task automatic test_missing_last();
        do_aw(4'h7, 32'h0000_4000, 3'd1, 2'b01, 2'b00);
        send_beat(64'hE000_0000_0000_0000, 8'hFF, 1'b0);
        send_beat(64'hE111_1111_1111_1111, 8'hFF, 1'b0);
        send_beat(64'hE222_2222_2222_2222, 8'hFF, 1'b0);
        send_beat(64'hE333_3333_3333_3333, 8'hFF, 1'b0);
        checks++;
        if (wready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL drain got wready=%b bvalid=%b exp 1 0", wready, bvalid);
        end
        send_beat(64'hE444_4444_4444_4444, 8'hFF, 1'b1);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b10 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun got bvalid=%b bresp=%b ov=%b exp 1 10 0", bvalid, bresp, out_valid);
        end
        checks++;
        if (out_strb !== 64'h0000_0000_0000_FFFF || out_data[64 +: 64] !== 64'hE111_1111_1111_1111 ||
            out_data[2*64 +: 64] !== 64'h3333_3333_3333_3333) begin
            errors++;
            $display("FAIL overrun_buf got strb=%h b1=%h b2=%h exp ffff e111.. 3333..",
                     out_strb, out_data[64 +: 64], out_data[2*64 +: 64]);
        end
        finish_b();
    endtask

    task automatic test_err_causes();
        do_aw(4'h8, 32'h0000_5000, 3'd0, 2'b00, 2'b00);
        send_beat(64'h7777_7777_7777_7777, 8'h0F, 1'b1);
        checks++;
        if (bresp !== 2'b10 || out_valid !== 1'b0 || out_strb !== 64'h0F) begin
            errors++;
            $display("FAIL fixed_burst got bresp=%b ov=%b strb=%h exp 10 0 0f", bresp, out_valid, out_strb);
        end
        finish_b();
        do_aw(4'h9, 32'h0000_6000, 3'd0, 2'b01, 2'b11);
        send_beat(64'h8888_8888_8888_8888, 8'hFF, 1'b1);
        checks++;
        if (bresp !== 2'b10 || out_valid !== 1'b0 || bid !== 4'h9) begin
            errors++;
            $display("FAIL unlucky got bresp=%b ov=%b bid=%h exp 10 0 9", bresp, out_valid, bid);
        end
        finish_b();
    endtask

    task automatic test_backpressure();
        do_aw(4'hA, 32'h0000_7000, 3'd0, 2'b01, 2'b10);
        send_beat(64'h9999_9999_9999_9999, 8'hFF, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b exp 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bid !== 4'hA || bresp !== 2'b00 || awready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got bvalid=%b bid=%h bresp=%b awready=%b exp 1 a 00 0",
                         i, bvalid, bid, bresp, awready);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 32'h0000_7000) begin
            errors++; $display("FAIL bp_out got ov=%b addr=%h exp 0 7000", out_valid, out_addr);
        end
        finish_b();
    endtask

    task automatic test_reset_mid_burst();
        do_aw(4'h3, 32'h0000_8000, 3'd7, 2'b01, 2'b00);
        send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0);
        send_beat(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0 || wready !== 1'b0 || out_strb !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset got aw=%b b=%b w=%b strb=%h exp 1 0 0 0",
                     awready, bvalid, wready, out_strb);
        end
        do_aw(4'h9, 32'h0000_9000, 3'd0, 2'b01, 2'b00);
        send_beat(64'hCCCC_CCCC_CCCC_CCCC, 8'hFF, 1'b1);
        checks++;
        if (bid !== 4'h9 || bresp !== 2'b00 || out_valid !== 1'b1 || out_strb !== 64'hFF) begin
            errors++;
            $display("FAIL post_reset got bid=%h bresp=%b ov=%b strb=%h exp 9 00 1 ff",
                     bid, bresp, out_valid, out_strb);
        end
        finish_b();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        awvalid = 1'b0;
        awid    = '0;
        awaddr  = '0;
        awlen   = '0;
        awburst = 2'b01;
        awsize  = '0;
        awuser  = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        bready  = 1'b0;
        test_reset();
        test_regular();
        test_w_before_aw();
        test_block();
        test_early_last();
        test_missing_last();
        test_err_causes();
        test_backpressure();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
